// File: rtl/axis_master_pkg.sv
// Shared types and defaults for the axis_master packet source.
package axis_master_pkg;

    localparam int unsigned BEATS_DEF  = 4;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Beat counter width, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/axis_beat_counter.sv
// Beat index within the current packet, with a look-ahead final-beat flag.
module axis_beat_counter
    import axis_master_pkg::*;
#(
    parameter int unsigned BEATS = BEATS_DEF,
    parameter int unsigned CNT_W = cnt_width(BEATS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             next_last_c
);

    // Clear wins over increment so a packet start always begins at beat 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    // High when the beat following the current one is the packet's last.
    assign next_last_c = ((32'(count) + 32'd1) == (32'(BEATS) - 32'd1));

endmodule

// File: rtl/axis_master.sv
// AXI4-Stream packet source: each request emits BEATS incrementing bytes.
module axis_master
    import axis_master_pkg::*;
#(
    parameter int unsigned BEATS  = BEATS_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              m_axis_clk,
    input  logic              m_axis_rstn,
    input  logic [DATA_W-1:0] din,
    input  logic              new_data,
    input  logic              m_axis_tready,
    output logic              m_axis_tvalid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast
);

    localparam int unsigned CNT_W = cnt_width(BEATS);

    state_t             state;
    logic [DATA_W-1:0]  base;
    logic [CNT_W-1:0]   count;
    logic               next_last;
    logic               hs;
    logic               start;
    logic               cnt_en;
    logic               cnt_clr;

    assign hs      = m_axis_tvalid && m_axis_tready;
    assign start   = (state == IDLE) && new_data;
    assign cnt_en  = (state == SEND) && hs && !m_axis_tlast;
    assign cnt_clr = start || ((state == SEND) && hs && m_axis_tlast);

    axis_beat_counter #(
        .BEATS (BEATS),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk         (m_axis_clk),
        .rst_n       (m_axis_rstn),
        .en          (cnt_en),
        .clr         (cnt_clr),
        .count       (count),
        .next_last_c (next_last)
    );

    // Packet FSM with base capture and registered stream outputs.
    always_ff @(posedge m_axis_clk or negedge m_axis_rstn) begin
        if (!m_axis_rstn) begin
            state         <= IDLE;
            base          <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (new_data) begin
                        base          <= din;
                        m_axis_tdata  <= din;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= (BEATS == 1);
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (m_axis_tlast) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            m_axis_tdata <= base + DATA_W'(count) + DATA_W'(1);
                            m_axis_tlast <= next_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_master.sv
// Scoreboard bench for axis_master with default BEATS=4, DATA_W=8.
module tb_axis_master;

    localparam int unsigned BEATS = 4;

    logic       clk;
    logic       rstn;
    logic [7:0] din;
    logic       new_data;
    logic       tready;
    logic       tvalid;
    logic [7:0] tdata;
    logic       tlast;

    int checks;
    int errors;
    int packets;
    bit busy;
    logic [8:0] q[$];

    axis_master #(.BEATS(BEATS), .DATA_W(8)) dut (
        .m_axis_clk    (clk),
        .m_axis_rstn   (rstn),
        .din           (din),
        .new_data      (new_data),
        .m_axis_tready (tready),
        .m_axis_tvalid (tvalid),
        .m_axis_tdata  (tdata),
        .m_axis_tlast  (tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model and monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rstn) begin
            q.delete();
            busy = 1'b0;
        end else if (busy) begin
            if (!tvalid) begin
                check("tvalid_busy", 32'(tvalid), 32'd1);
            end else if (tready) begin
                if (q.size() == 0) begin
                    check("extra_beat", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    check("tdata", 32'(tdata), 32'(e[7:0]));
                    check("tlast", 32'(tlast), 32'(e[8]));
                    if (e[8]) begin
                        busy = 1'b0;
                        packets++;
                    end
                end
            end else if (q.size() > 0) begin
                e = q[0];
                check("stall_tdata", 32'(tdata), 32'(e[7:0]));
                check("stall_tlast", 32'(tlast), 32'(e[8]));
            end
        end else begin
            check("idle_tvalid", 32'(tvalid), 32'd0);
            if (new_data) begin
                for (int i = 0; i < int'(BEATS); i++) begin
                    e[7:0] = din + 8'(i);
                    e[8]   = (i == int'(BEATS) - 1);
                    q.push_back(e);
                end
                busy = 1'b1;
            end
        end
    end

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (!busy && q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("idle_timeout", 32'(done), 32'd1);
    endtask

    task automatic send_one(input logic [7:0] b);
        @(posedge clk); #1;
        din      = b;
        new_data = 1'b1;
        @(posedge clk); #1;
        new_data = 1'b0;
        din      = 8'hA5;
        wait_idle();
    endtask

    initial begin
        int start_pkts;
        rstn     = 1'b0;
        din      = 8'h00;
        new_data = 1'b0;
        tready   = 1'b1;
        checks   = 0;
        errors   = 0;
        packets  = 0;
        busy     = 1'b0;

        // Reset held for 10 cycles.
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tlast", 32'(tlast), 32'd0);
        check("rst_tdata", 32'(tdata), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_rst_tvalid", 32'(tvalid), 32'd0);

        // Single packet and wrap.
        send_one(8'h24);
        send_one(8'hFE);
        check("pkts_after_single", 32'(packets), 32'd2);

        // Backpressure after the second handshake.
        @(posedge clk); #1;
        din      = 8'h10;
        new_data = 1'b1;
        @(posedge clk); #1;
        new_data = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_tdata", 32'(tdata), 32'h12);
            check("bp_tvalid", 32'(tvalid), 32'd1);
            @(posedge clk); #1;
        end
        tready = 1'b1;
        wait_idle();
        check("pkts_after_bp", 32'(packets), 32'd3);

        // Continuous requests with random din every cycle.
        start_pkts = packets;
        @(posedge clk); #1;
        new_data = 1'b1;
        for (int i = 0; i < 150; i++) begin
            din = 8'($urandom);
            @(posedge clk); #1;
            if (packets - start_pkts >= 5) break;
        end
        new_data = 1'b0;
        wait_idle();
        check("burst_pkts", 32'(packets - start_pkts >= 5), 32'd1);

        // Reset asserted while beat 2 is presented.
        @(posedge clk); #1;
        din      = 8'h40;
        new_data = 1'b1;
        @(posedge clk); #1;
        new_data = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_tdata", 32'(tdata), 32'h42);
        #1;
        rstn = 1'b0;
        #1;
        check("async_tvalid", 32'(tvalid), 32'd0);
        check("async_tlast", 32'(tlast), 32'd0);
        check("async_tdata", 32'(tdata), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        start_pkts = packets;
        send_one(8'h55);
        check("pkt_after_rst", 32'(packets - start_pkts), 32'd1);

        check("q_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
